// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a saturating
// stall counter for performance debug.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              id_reg_dst,
  input  logic              id_branch,
  input  logic              id_mem_read,
  input  logic              id_mem_to_reg,
  input  logic              id_mem_write,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic [1:0]        id_alu_op,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic              flush,
  output logic              ex_valid,
  output logic              ex_reg_dst,
  output logic              ex_branch,
  output logic              ex_mem_read,
  output logic              ex_mem_to_reg,
  output logic              ex_mem_write,
  output logic              ex_alu_src,
  output logic              ex_reg_write,
  output logic [1:0]        ex_alu_op,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic              pc_write,
  output logic              ifid_write,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  logic              r_valid;
  ctrl_t             r_ctrl;
  logic [4:0]        r_rs, r_rt, r_rd;
  logic [DATA_W-1:0] r_rdata1, r_rdata2, r_imm, r_pc4;
  logic [CNT_W-1:0]  r_stall_cnt;

  ctrl_t w_id_ctrl;
  logic  w_rt_match;
  logic  w_hazard;
  logic  w_stall;
  logic  w_bubble;
  logic  w_cnt_sat;

  assign w_id_ctrl = '{reg_dst: id_reg_dst, branch: id_branch, mem_read: id_mem_read,
                       mem_to_reg: id_mem_to_reg, mem_write: id_mem_write,
                       alu_src: id_alu_src, reg_write: id_reg_write, alu_op: id_alu_op};

  // Both source specifiers are checked regardless of opcode; register 0 never hazards.
  assign w_rt_match = (r_rt == id_rs) | (r_rt == id_rt);
  assign w_hazard   = id_valid & r_valid & r_ctrl.mem_read & (r_rt != 5'd0) & w_rt_match;
  assign w_stall    = w_hazard & ~flush;
  assign w_bubble   = flush | w_stall;
  assign w_cnt_sat  = &r_stall_cnt;

  assign pc_write   = ~w_stall;
  assign ifid_write = ~w_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_ctrl   <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_rd     <= '0;
      r_rdata1 <= '0;
      r_rdata2 <= '0;
      r_imm    <= '0;
      r_pc4    <= '0;
    end else if (w_bubble) begin
      r_valid  <= 1'b0;
      r_ctrl   <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_rd     <= '0;
      r_rdata1 <= '0;
      r_rdata2 <= '0;
      r_imm    <= '0;
      r_pc4    <= '0;
    end else begin
      // A non-valid slot keeps its data but can never write registers or memory.
      r_valid  <= id_valid;
      r_ctrl   <= id_valid ? w_id_ctrl : '0;
      r_rs     <= id_rs;
      r_rt     <= id_rt;
      r_rd     <= id_rd;
      r_rdata1 <= id_rdata1;
      r_rdata2 <= id_rdata2;
      r_imm    <= id_imm;
      r_pc4    <= id_pc4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_stall_cnt <= '0;
    else if (w_stall && !w_cnt_sat)  r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign ex_valid      = r_valid;
  assign ex_reg_dst    = r_ctrl.reg_dst;
  assign ex_branch     = r_ctrl.branch;
  assign ex_mem_read   = r_ctrl.mem_read;
  assign ex_mem_to_reg = r_ctrl.mem_to_reg;
  assign ex_mem_write  = r_ctrl.mem_write;
  assign ex_alu_src    = r_ctrl.alu_src;
  assign ex_reg_write  = r_ctrl.reg_write;
  assign ex_alu_op     = r_ctrl.alu_op;
  assign ex_rs         = r_rs;
  assign ex_rt         = r_rt;
  assign ex_rd         = r_rd;
  assign ex_rdata1     = r_rdata1;
  assign ex_rdata2     = r_rdata2;
  assign ex_imm        = r_imm;
  assign ex_pc4        = r_pc4;
  assign stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized checks of id_ex_stage against a cycle-level reference model.
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
  // control bit order {reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write}
  localparam logic [6:0] C_LW = 7'b0011011;
  localparam logic [6:0] C_RT = 7'b1000001;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_reg_dst, id_branch, id_mem_read, id_mem_to_reg, id_mem_write;
  logic id_alu_src, id_reg_write, flush;
  logic [1:0] id_alu_op;
  logic [4:0] id_rs, id_rt, id_rd;
  logic [DW-1:0] id_rdata1, id_rdata2, id_imm, id_pc4;
  logic ex_valid, ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write;
  logic ex_alu_src, ex_reg_write;
  logic [1:0] ex_alu_op;
  logic [4:0] ex_rs, ex_rt, ex_rd;
  logic [DW-1:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
  logic pc_write, ifid_write;
  logic [CW-1:0] stall_cnt;

  id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_reg_dst(id_reg_dst),
    .id_branch(id_branch), .id_mem_read(id_mem_read), .id_mem_to_reg(id_mem_to_reg),
    .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
    .id_alu_op(id_alu_op), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_pc4(id_pc4),
    .flush(flush), .ex_valid(ex_valid), .ex_reg_dst(ex_reg_dst), .ex_branch(ex_branch),
    .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
    .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write), .ex_alu_op(ex_alu_op),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_rdata1(ex_rdata1),
    .ex_rdata2(ex_rdata2), .ex_imm(ex_imm), .ex_pc4(ex_pc4), .pc_write(pc_write),
    .ifid_write(ifid_write), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: what the EX slot should hold, and the stall count.
  logic          m_valid;
  logic [6:0]    m_ctrl;
  logic [1:0]    m_op;
  logic [4:0]    m_rs, m_rt, m_rd;
  logic [DW-1:0] m_d1, m_d2, m_imm, m_pc4;
  int            m_cnt;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic bit model_hazard();
    return id_valid && m_valid && m_ctrl[4] && (m_rt != 0) &&
           ((m_rt == id_rs) || (m_rt == id_rt));
  endfunction

  task automatic model_clear();
    m_valid = 0; m_ctrl = 0; m_op = 0; m_rs = 0; m_rt = 0; m_rd = 0;
    m_d1 = 0; m_d2 = 0; m_imm = 0; m_pc4 = 0;
  endtask

  task automatic model_edge();
    bit st;
    st = model_hazard() && !flush;
    if (flush || st) begin
      model_clear();
      if (st && m_cnt < CNT_MAX) m_cnt++;
    end else begin
      m_valid = id_valid;
      m_ctrl  = id_valid ? {id_reg_dst, id_branch, id_mem_read, id_mem_to_reg,
                            id_mem_write, id_alu_src, id_reg_write} : 7'd0;
      m_op    = id_valid ? id_alu_op : 2'd0;
      m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
      m_d1 = id_rdata1; m_d2 = id_rdata2; m_imm = id_imm; m_pc4 = id_pc4;
    end
  endtask

  task automatic chk_hz();
    chk("pc_write", 64'(pc_write), 64'(!(model_hazard() && !flush)));
    chk("ifid_write", 64'(ifid_write), 64'(!(model_hazard() && !flush)));
  endtask

  task automatic chk_out();
    chk("ex_valid", 64'(ex_valid), 64'(m_valid));
    chk("ex_ctrl", 64'({ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write,
                        ex_alu_src, ex_reg_write}), 64'(m_ctrl));
    chk("ex_alu_op", 64'(ex_alu_op), 64'(m_op));
    chk("ex_regs", 64'({ex_rs, ex_rt, ex_rd}), 64'({m_rs, m_rt, m_rd}));
    chk("ex_rdata", {ex_rdata1, ex_rdata2}, {m_d1, m_d2});
    chk("ex_imm_pc4", {ex_imm, ex_pc4}, {m_imm, m_pc4});
    chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    chk_hz();
  endtask

  // Inputs are applied 1 time unit after a rising edge; this checks the
  // combinational hazard outputs, takes the edge, then checks the register.
  task automatic cycle();
    #1 chk_hz();
    @(posedge clk);
    model_edge();
    #1 chk_out();
  endtask

  task automatic id_set(input logic v, input logic [6:0] c, input logic [1:0] op,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [DW-1:0] d1, input logic fl);
    id_valid = v;
    {id_reg_dst, id_branch, id_mem_read, id_mem_to_reg, id_mem_write,
     id_alu_src, id_reg_write} = c;
    id_alu_op = op; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rdata1 = d1; id_rdata2 = d1 ^ 32'h5a5a_0000; id_imm = {27'd0, rd}; id_pc4 = d1 + 4;
    flush = fl;
  endtask

  task automatic load_use_pair(input logic [4:0] r);
    id_set(1, C_LW, 2'b00, 5'd1, r, 5'd0, 32'h100, 0); cycle();
    id_set(1, C_RT, 2'b10, r, 5'd2, 5'd3, 32'h200, 0); cycle();
    cycle();
  endtask

  initial begin
    rst_n = 0;
    id_set(0, 7'd0, 2'd0, 5'd0, 5'd0, 5'd0, 32'd0, 0);
    model_clear(); m_cnt = 0;
    #1 chk_out();
    chk("rst_pcw", 64'(pc_write), 64'd1);
    #11 rst_n = 1;
    @(posedge clk); #1;

    // R-type pass-through
    id_set(1, C_RT, 2'b10, 5'd1, 5'd2, 5'd3, 32'h11, 0);
    cycle();
    chk("rtype_rd", 64'(ex_rd), 64'd3);
    chk("rtype_d1", 64'(ex_rdata1), 64'h11);
    chk("rtype_op", 64'(ex_alu_op), 64'd2);

    // Load-use: lw rt=8 then add rs=8
    id_set(1, C_LW, 2'b00, 5'd4, 5'd8, 5'd0, 32'h40, 0); cycle();
    id_set(1, C_RT, 2'b10, 5'd8, 5'd9, 5'd10, 32'h80, 0);
    #1 chk("lu_pcw", 64'(pc_write), 64'd0);
    chk("lu_ifidw", 64'(ifid_write), 64'd0);
    cycle();
    chk("lu_bubble", 64'({ex_valid, ex_mem_read, ex_reg_write}), 64'd0);
    chk("lu_cnt", 64'(stall_cnt), 64'd1);
    cycle();
    chk("lu_capture", 64'({ex_valid, ex_rs, ex_rd}), 64'({1'b1, 5'd8, 5'd10}));

    // Register 0 exemption
    id_set(1, C_LW, 2'b00, 5'd4, 5'd0, 5'd0, 32'h44, 0); cycle();
    id_set(1, C_RT, 2'b10, 5'd0, 5'd0, 5'd5, 32'h48, 0);
    #1 chk("r0_pcw", 64'(pc_write), 64'd1);
    cycle();
    chk("r0_cnt", 64'(stall_cnt), 64'd1);

    // Flush beats hazard
    id_set(1, C_LW, 2'b00, 5'd4, 5'd9, 5'd0, 32'h50, 0); cycle();
    id_set(1, C_RT, 2'b10, 5'd1, 5'd9, 5'd6, 32'h54, 1);
    #1 chk("fl_pcw", 64'(pc_write), 64'd1);
    cycle();
    chk("fl_bubble", 64'(ex_valid), 64'd0);
    chk("fl_cnt", 64'(stall_cnt), 64'd1);

    // Non-valid slot: data captured, control forced off
    id_set(0, 7'h7f, 2'b11, 5'd7, 5'd8, 5'd9, 32'hdead, 0); cycle();

    // Reset mid-stream with ex_reg_write=1 and stall_cnt=5
    for (int i = 0; i < 4; i++) load_use_pair(5'd12);
    id_set(1, C_RT, 2'b10, 5'd1, 5'd2, 5'd3, 32'h99, 0); cycle();
    chk("pre_rst_rw", 64'(ex_reg_write), 64'd1);
    chk("pre_rst_cnt", 64'(stall_cnt), 64'd5);
    #2 rst_n = 0;
    model_clear(); m_cnt = 0;
    #1 chk_out();
    chk("mid_rst_pcw", 64'(pc_write), 64'd1);
    #1 rst_n = 1;
    @(posedge clk); #1;

    // Saturation
    for (int i = 0; i < 20; i++) load_use_pair(5'd5);
    chk("sat_cnt", 64'(stall_cnt), 64'd15);

    // Randomized traffic with small register specifiers to provoke hazards
    for (int i = 0; i < 400; i++) begin
      id_valid = ($urandom_range(9) < 8);
      {id_reg_dst, id_branch, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write} =
        6'($urandom);
      id_mem_read = $urandom_range(1);
      id_alu_op = 2'($urandom);
      id_rs = 5'($urandom_range(3));
      id_rt = 5'($urandom_range(3));
      id_rd = 5'($urandom);
      id_rdata1 = $urandom; id_rdata2 = $urandom; id_imm = $urandom; id_pc4 = $urandom;
      flush = ($urandom_range(7) == 0);
      cycle();
      if ($urandom_range(63) == 0) begin
        #2 rst_n = 0;
        model_clear(); m_cnt = 0;
        #1 chk_out();
        #1 rst_n = 1;
        @(posedge clk); model_edge(); #1 chk_out();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout got running exp finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with load-use hazard detection for the five-stage datapath. It sits directly downstream of the main control decoder and register file. Each cycle it captures the decoded control bits, operands and register specifiers, and presents them to the EX stage. When a load in EX feeds the instruction in ID, it stalls PC and IF/ID for one cycle and inserts a bubble into EX. It also keeps a saturating stall counter for performance debug.

## Interface
- DATA_W, 32, operand/immediate/PC width
- CNT_W, 16, stall counter width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_reg_dst, id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write  in  1 each  control decoder outputs
- id_alu_op  in  2  control decoder ALU op
- id_rs, id_rt, id_rd  in  5 each  register specifiers
- id_rdata1, id_rdata2, id_imm, id_pc4  in  DATA_W each  read data, sign-extended immediate, PC+4
- flush  in  1  branch taken: squash instruction in ID
- ex_* (one per id_* above, same widths, plus ex_valid)  out  registered ID/EX contents
- pc_write  out  1  PC update enable (0 = hold)
- ifid_write  out  1  IF/ID update enable (0 = hold)
- stall_cnt  out  CNT_W  saturating count of inserted load-use stalls

## Operation
- hazard = id_valid & ex_valid & ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
- Both rs and rt are compared for every opcode. This is conservative and intentional.
- stall = hazard & ~flush.
- pc_write = ifid_write = ~stall. These are combinational from current ID inputs and ID/EX state.
- Bubble load: every ex_* control bit = 0, ex_alu_op = 2'b00, ex_valid = 0. Data and specifier fields also load 0.
- Each rising edge, the register does exactly one of the following:
  - flush = 1: bubble load.
  - else stall = 1: bubble load, and stall_cnt increments.
  - else: capture all id_* inputs, with ex_valid = id_valid.
- When id_valid = 0 (and no flush or stall), all fields are captured as-is, but ex_valid = 0 and all control bits are forced to 0. A non-valid slot therefore never writes registers or memory.
- stall_cnt saturates at 2^CNT_W − 1 and does not wrap.
- Flush overrides hazard. The squashed ID instruction needs no stall, so pc_write = ifid_write = 1 and stall_cnt does not change.

## Timing
- Reset (rst_n low, asynchronous, effective immediately and mid-operation):
  - every ex_* output = 0, ex_valid = 0, stall_cnt = 0.
  - pc_write = ifid_write = 1, since hazard = 0 while ex_valid = 0.
- ID to EX latency: 1 cycle.
- Load-use stall lasts exactly 1 cycle. After the bubble, ex_mem_read = 0, so hazard clears. The held instruction is re-presented in ID and captured on the next edge.
- Back-to-back loads where the second load uses the first load's result: 1 stall. The second load then reaches EX and may stall its own consumer.
- Hazard outputs settle within the same cycle. There is no registered delay on pc_write/ifid_write.

## Test plan
- Reset mid-stream: with ex_reg_write = 1 and stall_cnt = 5, pull rst_n low between edges → all ex_* = 0 and stall_cnt = 0 before the next edge; pc_write = 1.
- R-type pass-through: id_rs=1, id_rt=2, id_rd=3, id_rdata1=0x11, id_reg_dst=1, id_alu_op=2'b10, id_reg_write=1, valid → next edge ex_* equal the inputs; no stall.
- Load-use: lw with rt=8 captured, then ID holds add with rs=8 → pc_write = ifid_write = 0 for 1 cycle; next edge ex_valid = 0 with all control 0; stall_cnt = 1; following edge the add is captured.
- Register 0 exemption: lw with rt=0 in EX, ID rs=0 → no stall; stall_cnt unchanged.
- Flush beats hazard: lw rt=9 in EX, ID rt=9, flush=1 → pc_write = 1, next edge bubble, stall_cnt unchanged.
- Saturation: CNT_W=4, 20 separate load-use pairs → stall_cnt = 15.
